led_show_scheduler: RTL
=======================

LED_SHOW_SCHEDULER -- requirements
Module: led_show_scheduler

Interface
REQ-001 SHALL have parameter: none; all widths fixed (led 16 bits, mode 2 bits, speed 3 bits).
REQ-002 SHALL have port: clkdiv  in  1  clock; all state updates on its rising edge.
REQ-003 SHALL have port: rst  in  1  reset; asynchronous, active-high.
REQ-004 SHALL have port: start  in  1  level-sampled; IDLE->RUN request.
REQ-005 SHALL have port: stop  in  1  level-sampled; any state->IDLE.
REQ-006 SHALL have port: pause  in  1  level; freezes pattern while high.
REQ-007 SHALL have port: req_valid  in  1  pattern-change request valid.
REQ-008 SHALL have port: req_mode  in  2  requested mode (0 WALK, 1 BOUNCE, 2 FILL, 3 BLINK).
REQ-009 SHALL have port: req_speed  in  3  requested step divider; step period = req_speed+1 cycles.
REQ-010 SHALL have port: req_ready  out  1  high when no request is pending (= !pend_valid).
REQ-011 SHALL have port: led  out  16  registered LED pattern.
REQ-012 SHALL have port: state  out  2  FSM state (0 IDLE, 1 RUN, 2 HOLD).
REQ-013 SHALL have port: wrap  out  1  registered one-cycle pulse on pattern period completion.

Function
REQ-014 SHALL implement FSM IDLE/RUN/HOLD; priority per cycle: stop > start > pause.
REQ-015 IDLE: led=0x0000; start -> RUN, led loads init(cur_mode), tick_cnt=0, dir=right.
REQ-016 RUN: stop -> IDLE (led=0x0000 next cycle); pause -> HOLD; else tick.
REQ-017 HOLD: led, tick_cnt, dir frozen; stop -> IDLE; pause low -> RUN, resuming from frozen tick_cnt.
REQ-018 Tick in RUN: if tick_cnt==cur_speed, step occurs and tick_cnt<=0; else tick_cnt+1. Step period exactly cur_speed+1 cycles.
REQ-019 Handshake: accept when req_valid && req_ready; capture pend_mode, pend_speed; set pend_valid; req_ready low next cycle.
REQ-020 Pending apply, IDLE: the cycle after accept, cur_mode/cur_speed <= pending, pend_valid cleared.
REQ-021 Pending apply, RUN: on the next step cycle, led <= init(pend_mode), cur_* updated, tick_cnt=0, dir=right, pend_valid cleared, no pattern advance, no wrap.
REQ-022 Pending in HOLD: retained; applied at first step after returning to RUN.
REQ-023 start with pend_valid set in IDLE: pending applied first; led loads init(pend_mode) same cycle.
REQ-024 stop with pend_valid set: pending retained; applied in IDLE next cycle.
REQ-025 req_ready SHALL rise the cycle after pend_valid clears; no accept possible in the apply cycle.
REQ-026 WALK: init 0x8000; step led>>1; 0x0001 -> 0x8000 with wrap=1; period 16 steps.
REQ-027 BOUNCE: init 0x8000, dir right; right shift until 0x0001, then dir=left; left shift until 0x8000, then dir=right; wrap=1 on step into 0x8000; period 30 steps.
REQ-028 FILL: init 0x0000; step led <= {1'b1, led[15:1]}; 0xFFFF -> 0x0000 with wrap=1; period 17 steps.
REQ-029 BLINK: init 0xFFFF; step led <= ~led; wrap=1 on 0x0000 -> 0xFFFF; period 2 steps.
REQ-030 wrap SHALL be 0 in every cycle other than the wrapping step.
REQ-031 Out-of-sequence led value (not reachable from the mode init) SHALL step to init(cur_mode) with wrap=0.

Reset
REQ-032 rst high SHALL immediately force: state=IDLE, led=0x0000, wrap=0, req_ready=1, pend_valid=0, cur_mode=0, cur_speed=0, tick_cnt=0, dir=right.
REQ-033 rst asserted mid-pattern or with a pending request SHALL discard all state; first post-reset start runs WALK at speed 0.

Verification
REQ-034 Reset, start=1 for 1 cycle -> led 0x8000, 0x4000, ... 0x0001, 0x8000 on consecutive cycles; wrap=1 exactly with the 0x8000 reload.
REQ-035 Request mode=1 speed=2 during RUN -> req_ready low; at next step led=0x8000; then led changes every 3 cycles; the sequence reaches 0x0001 and returns to 0x8000 after 30 steps with one wrap.
REQ-036 FILL speed=0: led 0x0000, 0x8000, 0xC000, ..., 0xFFFF, 0x0000 (wrap); pause high 5 cycles mid-sequence -> state=2 and led constant; release -> continues from the same value.
REQ-037 stop and start high in the same cycle in RUN -> state=IDLE, led=0x0000; a request accepted in IDLE -> cur_* updated next cycle, req_ready back high the cycle after.
REQ-038 Async rst mid-BLINK with request pending -> led=0x0000, req_ready=1, state=0 without a clock edge; next start gives led=0x8000 (WALK).

Source files
------------

// File: rtl/led_show_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : led_show_scheduler
// Function : IDLE/RUN/HOLD LED pattern sequencer (WALK, BOUNCE, FILL, BLINK)
//            with a one-deep mode/speed change request buffer.
// Revision : 1.0 - initial release
// ============================================================================
module led_show_scheduler (
    input  logic        clkdiv,
    input  logic        rst,
    input  logic        start,
    input  logic        stop,
    input  logic        pause,
    input  logic        req_valid,
    input  logic [1:0]  req_mode,
    input  logic [2:0]  req_speed,
    output logic        req_ready,
    output logic [15:0] led,
    output logic [1:0]  state,
    output logic        wrap
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam logic [1:0] c_WALK      = 2'd0;
    localparam logic [1:0] c_BOUNCE    = 2'd1;
    localparam logic [1:0] c_FILL      = 2'd2;
    localparam logic [1:0] c_BLINK     = 2'd3;
    localparam logic       c_DIR_RIGHT = 1'b0;
    localparam logic       c_DIR_LEFT  = 1'b1;

    state_t      r_state,      w_state_nxt;
    logic [15:0] r_led,        w_led_nxt;
    logic        r_wrap,       w_wrap_nxt;
    logic [2:0]  r_tick,       w_tick_nxt;
    logic        r_dir,        w_dir_nxt;
    logic [1:0]  r_cur_mode,   w_cur_mode_nxt;
    logic [2:0]  r_cur_speed,  w_cur_speed_nxt;
    logic        r_pend_valid, w_pend_valid_nxt;
    logic [1:0]  r_pend_mode,  w_pend_mode_nxt;
    logic [2:0]  r_pend_speed, w_pend_speed_nxt;

    logic [15:0] w_step_led;
    logic        w_step_dir;
    logic        w_step_wrap;
    logic [15:0] w_not_led;
    logic        w_onehot;
    logic        w_fill_ok;

    function automatic logic [15:0] f_init(input logic [1:0] mode);
        case (mode)
            c_FILL:  f_init = 16'h0000;
            c_BLINK: f_init = 16'hFFFF;
            default: f_init = 16'h8000;
        endcase
    endfunction

    assign w_not_led = ~r_led;
    assign w_onehot  = (r_led != 16'h0000) && ((r_led & (r_led - 16'd1)) == 16'h0000);
    // FILL values are a run of ones from the MSB down, i.e. ~led is a low-aligned mask.
    assign w_fill_ok = ((w_not_led & (w_not_led + 16'd1)) == 16'h0000);

    // Next pattern value; anything unreachable from the mode's init falls back to init.
    always_comb begin
        w_step_led  = f_init(r_cur_mode);
        w_step_dir  = c_DIR_RIGHT;
        w_step_wrap = 1'b0;
        case (r_cur_mode)
            c_WALK: begin
                if (r_led == 16'h0001) begin
                    w_step_led  = 16'h8000;
                    w_step_wrap = 1'b1;
                end else if (w_onehot) begin
                    w_step_led = r_led >> 1;
                end
            end
            c_BOUNCE: begin
                if (w_onehot) begin
                    if (r_dir == c_DIR_RIGHT) begin
                        if (r_led == 16'h0001) begin
                            w_step_led = 16'h0002;
                            w_step_dir = c_DIR_LEFT;
                        end else begin
                            w_step_led = r_led >> 1;
                            w_step_dir = (r_led == 16'h0002) ? c_DIR_LEFT : c_DIR_RIGHT;
                        end
                    end else begin
                        if (r_led == 16'h8000) begin
                            w_step_led = 16'h4000;
                            w_step_dir = c_DIR_RIGHT;
                        end else begin
                            w_step_led  = r_led << 1;
                            w_step_dir  = (r_led == 16'h4000) ? c_DIR_RIGHT : c_DIR_LEFT;
                            w_step_wrap = (r_led == 16'h4000);
                        end
                    end
                end
            end
            c_FILL: begin
                if (r_led == 16'hFFFF) begin
                    w_step_led  = 16'h0000;
                    w_step_wrap = 1'b1;
                end else if (w_fill_ok) begin
                    w_step_led = {1'b1, r_led[15:1]};
                end
            end
            default: begin
                if (r_led == 16'h0000) begin
                    w_step_led  = 16'hFFFF;
                    w_step_wrap = 1'b1;
                end else if (r_led == 16'hFFFF) begin
                    w_step_led = 16'h0000;
                end
            end
        endcase
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_led_nxt        = r_led;
        w_wrap_nxt       = 1'b0;
        w_tick_nxt       = r_tick;
        w_dir_nxt        = r_dir;
        w_cur_mode_nxt   = r_cur_mode;
        w_cur_speed_nxt  = r_cur_speed;
        w_pend_valid_nxt = r_pend_valid;
        w_pend_mode_nxt  = r_pend_mode;
        w_pend_speed_nxt = r_pend_speed;

        // Accept and apply are mutually exclusive: one needs pend_valid low, the other high.
        if (req_valid && !r_pend_valid) begin
            w_pend_valid_nxt = 1'b1;
            w_pend_mode_nxt  = req_mode;
            w_pend_speed_nxt = req_speed;
        end

        case (r_state)
            ST_IDLE: begin
                w_led_nxt  = 16'h0000;
                w_tick_nxt = 3'd0;
                w_dir_nxt  = c_DIR_RIGHT;
                if (r_pend_valid) begin
                    w_cur_mode_nxt   = r_pend_mode;
                    w_cur_speed_nxt  = r_pend_speed;
                    w_pend_valid_nxt = 1'b0;
                end
                if (start && !stop) begin
                    w_state_nxt = ST_RUN;
                    w_led_nxt   = f_init(r_pend_valid ? r_pend_mode : r_cur_mode);
                end
            end
            ST_RUN: begin
                if (stop) begin
                    w_state_nxt = ST_IDLE;
                    w_led_nxt   = 16'h0000;
                    w_tick_nxt  = 3'd0;
                    w_dir_nxt   = c_DIR_RIGHT;
                end else if (pause) begin
                    w_state_nxt = ST_HOLD;
                end else if (r_tick == r_cur_speed) begin
                    w_tick_nxt = 3'd0;
                    if (r_pend_valid) begin
                        w_cur_mode_nxt   = r_pend_mode;
                        w_cur_speed_nxt  = r_pend_speed;
                        w_pend_valid_nxt = 1'b0;
                        w_led_nxt        = f_init(r_pend_mode);
                        w_dir_nxt        = c_DIR_RIGHT;
                    end else begin
                        w_led_nxt  = w_step_led;
                        w_dir_nxt  = w_step_dir;
                        w_wrap_nxt = w_step_wrap;
                    end
                end else begin
                    w_tick_nxt = r_tick + 3'd1;
                end
            end
            ST_HOLD: begin
                if (stop) begin
                    w_state_nxt = ST_IDLE;
                    w_led_nxt   = 16'h0000;
                    w_tick_nxt  = 3'd0;
                    w_dir_nxt   = c_DIR_RIGHT;
                end else if (!pause) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_led_nxt   = 16'h0000;
                w_tick_nxt  = 3'd0;
                w_dir_nxt   = c_DIR_RIGHT;
            end
        endcase
    end

    always_ff @(posedge clkdiv or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_led        <= 16'h0000;
            r_wrap       <= 1'b0;
            r_tick       <= 3'd0;
            r_dir        <= c_DIR_RIGHT;
            r_cur_mode   <= c_WALK;
            r_cur_speed  <= 3'd0;
            r_pend_valid <= 1'b0;
            r_pend_mode  <= 2'd0;
            r_pend_speed <= 3'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_led        <= w_led_nxt;
            r_wrap       <= w_wrap_nxt;
            r_tick       <= w_tick_nxt;
            r_dir        <= w_dir_nxt;
            r_cur_mode   <= w_cur_mode_nxt;
            r_cur_speed  <= w_cur_speed_nxt;
            r_pend_valid <= w_pend_valid_nxt;
            r_pend_mode  <= w_pend_mode_nxt;
            r_pend_speed <= w_pend_speed_nxt;
        end
    end

    assign req_ready = !r_pend_valid;
    assign led       = r_led;
    assign state     = r_state;
    assign wrap      = r_wrap;

endmodule
`default_nettype wire
